convo_fifo_loader: RTL and testbench

CONVO_FIFO_LOADER -- requirements
Module: convo_fifo_loader

---
 rtl/convo_fifo_loader.sv | 152 +++++++++++++++
 tb/tb_convo_fifo_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/convo_fifo_loader.sv
// Streams one row-major feature map from memory into a line-buffer FIFO.
// Latency: first FIFO write 2 cycles after an accepted start, then one pixel per cycle.
// Backpressure: ff_full stalls writes; reads throttle so at most 2 pixels sit in flight/buffered.
module convo_fifo_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        row_len,
  input  logic [4:0]        col_len,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ff_wen,
  output logic [DATA_W-1:0] ff_wdata,
  input  logic              ff_full,
  output logic              load_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, PRELOAD, STREAM, FINISH} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [9:0]        total_q;
  logic [9:0]        preload_q;
  logic [9:0]        rd_cnt;
  logic [9:0]        wr_cnt;
  logic [9:0]        wr_next;
  logic [DATA_W-1:0] buf0;      // oldest buffered pixel
  logic [DATA_W-1:0] buf1;
  logic [1:0]        buf_cnt;
  logic              inflight;
  logic              err_q;

  logic              geom_ok;
  logic              accept;
  logic              active;
  logic              drain;
  logic              push;
  logic              pop;
  logic [2:0]        occ;

  assign geom_ok = (row_len >= 5'd3) && (col_len >= 5'd3);
  assign accept  = (state == IDLE) && start && geom_ok;
  assign active  = (state == PRELOAD) || (state == STREAM);

  // Returning read data may go straight to the FIFO when the buffer is empty;
  // that bypass is what gives the 2-cycle start-to-first-write latency.
  assign drain   = ((buf_cnt != 2'd0) || inflight) && !ff_full;
  assign pop     = drain && (buf_cnt != 2'd0);
  assign push    = inflight && !(drain && (buf_cnt == 2'd0));

  // Pixels already committed (buffered + returning) must stay below 2 after this cycle's drain.
  assign occ     = {1'b0, buf_cnt} + {2'b00, inflight};
  assign mem_ren = active && (rd_cnt < total_q) && (occ < (3'd2 + {2'b00, drain}));
  assign mem_addr = base_q + ADDR_W'(rd_cnt);

  assign ff_wen    = drain;
  assign ff_wdata  = drain ? ((buf_cnt != 2'd0) ? buf0 : mem_rdata) : '0;
  assign wr_next   = wr_cnt + 10'd1;
  assign load_done = drain && (state == PRELOAD) && (wr_next == preload_q);
  assign done      = drain && active && (wr_next == total_q);
  assign busy      = active;
  assign err       = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: done takes priority so a map whose preload equals its size ends cleanly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PRELOAD;
      PRELOAD: begin
        if (done)           state_nxt = FINISH;
        else if (load_done) state_nxt = STREAM;
      end
      STREAM:  if (done) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Geometry capture on accepted start; read/write counters otherwise advance on strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      total_q   <= '0;
      preload_q <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else if (accept) begin
      base_q    <= base_addr;
      total_q   <= 10'(row_len) * 10'(col_len);
      preload_q <= 10'({row_len, 1'b0}) + 10'd3;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      if (mem_ren) rd_cnt <= rd_cnt + 10'd1;
      if (drain)   wr_cnt <= wr_next;
    end
  end

  // Two-entry output buffer plus in-flight tracking; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0     <= '0;
      buf1     <= '0;
      buf_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_ren;
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= mem_rdata;
          else                 buf1 <= mem_rdata;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= mem_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Rejected-geometry pulse, one cycle after the offending start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state == IDLE) && start && !geom_ok;
  end

endmodule

// File: tb/tb_convo_fifo_loader.sv
module tb_convo_fifo_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [4:0]  row_len;
  logic [4:0]  col_len;
  logic        mem_ren;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        ff_wen;
  logic [15:0] ff_wdata;
  logic        ff_full;
  logic        load_done;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] mem [0:1023];

  always #5 clk = ~clk;

  convo_fifo_loader #(.DATA_W(16), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .row_len(row_len), .col_len(col_len), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .ff_wen(ff_wen), .ff_wdata(ff_wdata), .ff_full(ff_full),
    .load_done(load_done), .busy(busy), .done(done), .err(err)
  );

  // Memory model: data valid exactly one cycle after the read strobe, junk otherwise.
  always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_addr] : 16'($urandom);

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
  endtask

  task automatic check_all_zero(input string nm);
    logic [47:0] obs;
    obs = {mem_ren, ff_wen, load_done, busy, done, err, mem_addr, ff_wdata, 6'd0};
    n_chk++;
    if (obs !== 48'd0) begin
      n_bad++;
      $display("FAIL %s outputs: ren=%b wen=%b ld=%b busy=%b done=%b err=%b addr=%h wdata=%h required all 0",
               nm, mem_ren, ff_wen, load_done, busy, done, err, mem_addr, ff_wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; row_len = '0; col_len = '0; ff_full = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Loads one map and checks it against the reference: writes are mem[(b+i) mod 1024] for
  // i < r*c in order, load_done on write 2r+3, done on write r*c, busy until done.
  task automatic run_map(input logic [9:0] b, input int r, input int c,
                         input int stall_at, input int stall_len, input int full_pct,
                         input int restart_at, input int reset_at, input string nm);
    int tot, pre, nrd, nwr, nld, ndone, stall_cyc, first_cyc, done_cyc;
    bit fin, aborted;
    logic [9:0] exp_addr, idx;
    tot = r * c; pre = 2 * r + 3;
    nrd = 0; nwr = 0; nld = 0; ndone = 0;
    stall_cyc = -1; first_cyc = -1; done_cyc = -1; fin = 0; aborted = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; row_len = 5'(r); col_len = 5'(c); ff_full = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_in_start_cycle: got %b need 0", nm, busy); end
    for (int cyc = 1; cyc < 4000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == restart_at);
      if (start) begin base_addr = 10'h200; row_len = 5'd4; col_len = 5'd4; end
      ff_full = (stall_cyc >= 0 && cyc > stall_cyc && cyc <= stall_cyc + stall_len) ||
                (full_pct > 0 && $urandom_range(99) < full_pct);
      @(negedge clk);
      n_chk++;
      if (ff_full && ff_wen) begin n_bad++; $display("FAIL %s wen_while_full: cyc %0d", nm, cyc); end
      n_chk++;
      if (nrd - nwr > 2) begin n_bad++; $display("FAIL %s outstanding: got %0d need <=2", nm, nrd - nwr); end
      n_chk++;
      if (err !== 1'b0) begin n_bad++; $display("FAIL %s err: got %b need 0", nm, err); end
      n_chk++;
      if (done_cyc < 0) begin
        if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy: cyc %0d got %b need 1", nm, cyc, busy); end
      end else begin
        if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_after_done: got %b need 0", nm, busy); end
        fin = 1;
      end
      if (mem_ren) begin
        exp_addr = b + 10'(nrd);
        n_chk++;
        if (mem_addr !== exp_addr) begin
          n_bad++; $display("FAIL %s mem_addr: read %0d got %h need %h", nm, nrd, mem_addr, exp_addr);
        end
        n_chk++;
        if (nrd >= tot) begin n_bad++; $display("FAIL %s extra_read: read %0d of %0d", nm, nrd, tot); end
        nrd++;
      end
      if (ff_wen) begin
        nwr++;
        idx = b + 10'(nwr - 1);
        if (first_cyc < 0) first_cyc = cyc;
        if (nwr == stall_at) stall_cyc = cyc;
        n_chk++;
        if (ff_wdata !== mem[idx]) begin
          n_bad++; $display("FAIL %s wdata: write %0d got %h need %h", nm, nwr, ff_wdata, mem[idx]);
        end
        n_chk++;
        if (load_done !== (nwr == pre)) begin
          n_bad++; $display("FAIL %s load_done: write %0d got %b need %b", nm, nwr, load_done, nwr == pre);
        end
        n_chk++;
        if (done !== (nwr == tot)) begin
          n_bad++; $display("FAIL %s done: write %0d got %b need %b", nm, nwr, done, nwr == tot);
        end
        if (load_done) nld++;
        if (done) begin ndone++; done_cyc = cyc; end
        if (nwr == reset_at) begin
          rst_n = 1'b0;
          ff_full = 1'b0;
          start = 1'b0;
          #1;
          check_all_zero({nm, "_async_reset"});
          aborted = 1; fin = 1;
        end
      end else begin
        n_chk++;
        if (load_done !== 1'b0 || done !== 1'b0) begin
          n_bad++; $display("FAIL %s pulse_without_write: ld=%b done=%b need 0 0", nm, load_done, done);
        end
      end
    end
    if (!aborted) begin
      n_chk++;
      if (!fin) begin n_bad++; $display("FAIL %s timeout: writes %0d of %0d", nm, nwr, tot); end
      n_chk++;
      if (nld != 1 || ndone != 1) begin
        n_bad++; $display("FAIL %s pulse_count: load_done %0d done %0d need 1 1", nm, nld, ndone);
      end
      n_chk++;
      if (nwr != tot || nrd != tot) begin
        n_bad++; $display("FAIL %s totals: writes %0d reads %0d need %0d", nm, nwr, nrd, tot);
      end
      if (stall_at < 0 && full_pct == 0) begin
        n_chk++;
        if (first_cyc != 2) begin n_bad++; $display("FAIL %s latency: got %0d need 2", nm, first_cyc); end
      end
    end
    start = 1'b0;
    ff_full = 1'b0;
  endtask

  task automatic test_basic();
    run_map(10'h100, 5, 5, -1, 0, 0, -1, -1, "basic5x5");
  endtask

  task automatic test_stall();
    run_map(10'h100, 5, 5, 7, 4, 0, -1, -1, "stall");
  endtask

  task automatic test_bad_geometry();
    int rr [2] = '{2, 8};
    int cc [2] = '{8, 2};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 start = 1'b1; base_addr = 10'h040; row_len = 5'(rr[k]); col_len = 5'(cc[k]);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      n_chk++;
      if (err !== 1'b1 || busy !== 1'b0 || mem_ren !== 1'b0) begin
        n_bad++; $display("FAIL bad_geom_%0d: err=%b busy=%b ren=%b need 1 0 0", k, err, busy, mem_ren);
      end
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        n_chk++;
        if (err !== 1'b0 || busy !== 1'b0 || mem_ren !== 1'b0) begin
          n_bad++; $display("FAIL bad_geom_quiet_%0d: err=%b busy=%b ren=%b need 0 0 0", k, err, busy, mem_ren);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    run_map(10'h100, 5, 5, -1, 0, 0, 5, -1, "restart");
  endtask

  task automatic test_reset_mid_load();
    run_map(10'h100, 5, 5, -1, 0, 0, -1, 10, "midload");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    run_map(10'h020, 3, 3, -1, 0, 0, -1, -1, "after_reset3x3");
  endtask

  task automatic test_wrap();
    run_map(10'h3FE, 3, 3, -1, 0, 0, -1, -1, "wrap");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_map(10'($urandom), $urandom_range(3, 10), $urandom_range(3, 10),
              -1, 0, 30, -1, -1, "random");
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_basic();
    test_stall();
    test_bad_geometry();
    test_restart_ignored();
    test_reset_mid_load();
    test_wrap();
    fill_mem();
    test_random();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
